// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - arbitrates one shared ALU between core and coprocessor (IDLE/EXEC/RESP)
// Optional round-robin conflict resolution: ALU_ARB_RR_EN (undefined = core has fixed priority)
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req_valid,
    output logic            core_req_ready,
    input  logic [3:0]      core_req_ctrl,
    input  logic [XLEN-1:0] core_req_a,
    input  logic [XLEN-1:0] core_req_b,
    output logic            core_rsp_valid,
    input  logic            core_rsp_ready,
    output logic [XLEN-1:0] core_rsp_data,
    output logic            core_rsp_zero,
    output logic            core_rsp_err,
    input  logic            cop_req_valid,
    output logic            cop_req_ready,
    input  logic [3:0]      cop_req_ctrl,
    input  logic [XLEN-1:0] cop_req_a,
    input  logic [XLEN-1:0] cop_req_b,
    output logic            cop_rsp_valid,
    input  logic            cop_rsp_ready,
    output logic [XLEN-1:0] cop_rsp_data,
    output logic            cop_rsp_zero,
    output logic            cop_rsp_err,
    output logic [3:0]      alu_ctrl_o,
    output logic [XLEN-1:0] alu_a_o,
    output logic [XLEN-1:0] alu_b_o,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic            alu_zero_i,
    output logic            busy
);
    localparam logic [3:0] CTRL_ADD = 4'b0010;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic            owner_cop;
    logic            grant_cop;
    logic            accept;
    logic            legal;
    logic            rsp_done;
    logic [3:0]      sel_ctrl;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_zero;
    logic            rsp_err;

`ifdef ALU_ARB_RR_EN
    logic last_cop;
`endif

    always_comb begin
        grant_cop = 1'b0;
        if (cop_req_valid && !core_req_valid) begin
            grant_cop = 1'b1;
        end
`ifdef ALU_ARB_RR_EN
        else if (cop_req_valid && core_req_valid) begin
            grant_cop = !last_cop;
        end
`endif
    end

    assign core_req_ready = rst_n && (state == IDLE) && core_req_valid && !grant_cop;
    assign cop_req_ready  = rst_n && (state == IDLE) && cop_req_valid && grant_cop;
    assign accept         = core_req_ready || cop_req_ready;

    assign sel_ctrl = grant_cop ? cop_req_ctrl : core_req_ctrl;
    assign sel_a    = grant_cop ? cop_req_a    : core_req_a;
    assign sel_b    = grant_cop ? cop_req_b    : core_req_b;

    always_comb begin
        case (sel_ctrl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
    end

    assign rsp_done = owner_cop ? cop_rsp_ready : core_rsp_ready;

    // alu_*_o double as the latched operand registers; they only hold a request during EXEC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner_cop      <= 1'b0;
            core_rsp_valid <= 1'b0;
            cop_rsp_valid  <= 1'b0;
            rsp_data       <= '0;
            rsp_zero       <= 1'b0;
            rsp_err        <= 1'b0;
            alu_ctrl_o     <= CTRL_ADD;
            alu_a_o        <= '0;
            alu_b_o        <= '0;
`ifdef ALU_ARB_RR_EN
            last_cop       <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_cop <= grant_cop;
`ifdef ALU_ARB_RR_EN
                        last_cop  <= grant_cop;
`endif
                        if (legal) begin
                            alu_ctrl_o <= sel_ctrl;
                            alu_a_o    <= sel_a;
                            alu_b_o    <= sel_b;
                            state      <= EXEC;
                        end else begin
                            rsp_data       <= '0;
                            rsp_zero       <= 1'b0;
                            rsp_err        <= 1'b1;
                            core_rsp_valid <= !grant_cop;
                            cop_rsp_valid  <= grant_cop;
                            state          <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_data       <= alu_result_i;
                    rsp_zero       <= alu_zero_i;
                    rsp_err        <= 1'b0;
                    core_rsp_valid <= !owner_cop;
                    cop_rsp_valid  <= owner_cop;
                    alu_ctrl_o     <= CTRL_ADD;
                    alu_a_o        <= '0;
                    alu_b_o        <= '0;
                    state          <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        core_rsp_valid <= 1'b0;
                        cop_rsp_valid  <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_rsp_data = rsp_data;
    assign core_rsp_zero = rsp_zero;
    assign core_rsp_err  = rsp_err;
    assign cop_rsp_data  = rsp_data;
    assign cop_rsp_zero  = rsp_zero;
    assign cop_rsp_err   = rsp_err;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req_valid, core_req_ready, core_rsp_valid, core_rsp_ready;
    logic [3:0]  core_req_ctrl;
    logic [31:0] core_req_a, core_req_b, core_rsp_data;
    logic        core_rsp_zero, core_rsp_err;
    logic        cop_req_valid, cop_req_ready, cop_rsp_valid, cop_rsp_ready;
    logic [3:0]  cop_req_ctrl;
    logic [31:0] cop_req_a, cop_req_b, cop_rsp_data;
    logic        cop_rsp_zero, cop_rsp_err;
    logic [3:0]  alu_ctrl_o;
    logic [31:0] alu_a_o, alu_b_o, alu_result_i;
    logic        alu_zero_i, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_ctrl(core_req_ctrl), .core_req_a(core_req_a), .core_req_b(core_req_b),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_data(core_rsp_data), .core_rsp_zero(core_rsp_zero), .core_rsp_err(core_rsp_err),
        .cop_req_valid(cop_req_valid), .cop_req_ready(cop_req_ready),
        .cop_req_ctrl(cop_req_ctrl), .cop_req_a(cop_req_a), .cop_req_b(cop_req_b),
        .cop_rsp_valid(cop_rsp_valid), .cop_rsp_ready(cop_rsp_ready),
        .cop_rsp_data(cop_rsp_data), .cop_rsp_zero(cop_rsp_zero), .cop_rsp_err(cop_rsp_err),
        .alu_ctrl_o(alu_ctrl_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .busy(busy)
    );

    always_comb begin
        case (alu_ctrl_o)
            4'b0000: alu_result_i = alu_a_o & alu_b_o;
            4'b0001: alu_result_i = alu_a_o | alu_b_o;
            4'b0010: alu_result_i = alu_a_o + alu_b_o;
            4'b0110: alu_result_i = alu_a_o - alu_b_o;
            4'b0111: alu_result_i = {31'd0, $signed(alu_a_o) < $signed(alu_b_o)};
            4'b1000: alu_result_i = {31'd0, alu_a_o < alu_b_o};
            4'b1001: alu_result_i = alu_a_o ^ alu_b_o;
            4'b1010: alu_result_i = alu_a_o << alu_b_o[4:0];
            4'b1011: alu_result_i = alu_a_o >> alu_b_o[4:0];
            4'b1100: alu_result_i = $unsigned($signed(alu_a_o) >>> alu_b_o[4:0]);
            default: alu_result_i = 32'd0;
        endcase
        alu_zero_i = (alu_result_i == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        who;
        logic [3:0]  ctrl;
        logic [31:0] a, b, d;
        logic        z, e;
        int          lat;
    } vec_t;

    vec_t vt[12];

    task automatic drive_req(input logic who, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        if (who) begin
            cop_req_valid = 1'b1; cop_req_ctrl = ctrl; cop_req_a = a; cop_req_b = b;
        end else begin
            core_req_valid = 1'b1; core_req_ctrl = ctrl; core_req_a = a; core_req_b = b;
        end
    endtask

    // one complete transaction: request, accept, wait for response, check latency and payload
    task automatic run_op(input string name, input vec_t v);
        int   n;
        int   lat;
        logic other_seen;
        logic ctrl_bad;
        @(negedge clk);
        core_rsp_ready = 1'b1; cop_rsp_ready = 1'b1;
        drive_req(v.who, v.ctrl, v.a, v.b);
        #1;
        n = 0;
        while (!(v.who ? cop_req_ready : core_req_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({name, " accept"}, {31'd0, v.who ? cop_req_ready : core_req_ready}, 32'd1);
        @(posedge clk); #1;
        core_req_valid = 1'b0; cop_req_valid = 1'b0;
        lat = 1; other_seen = 1'b0; ctrl_bad = 1'b0;
        @(negedge clk); #1;
        while (!(v.who ? cop_rsp_valid : core_rsp_valid) && lat < 20) begin
            other_seen |= (v.who ? core_rsp_valid : cop_rsp_valid);
            ctrl_bad   |= v.e && (alu_ctrl_o != 4'b0010);
            @(negedge clk); #1; lat++;
        end
        other_seen |= (v.who ? core_rsp_valid : cop_rsp_valid);
        ctrl_bad   |= v.e && (alu_ctrl_o != 4'b0010);
        chk({name, " latency"}, lat, v.lat);
        chk({name, " data"}, v.who ? cop_rsp_data : core_rsp_data, v.d);
        chk({name, " zero"}, {31'd0, v.who ? cop_rsp_zero : core_rsp_zero}, {31'd0, v.z});
        chk({name, " err"}, {31'd0, v.who ? cop_rsp_err : core_rsp_err}, {31'd0, v.e});
        chk({name, " other_rsp_valid"}, {31'd0, other_seen}, 32'd0);
        if (v.e) chk({name, " alu_ctrl"}, {31'd0, ctrl_bad}, 32'd0);
    endtask

    initial begin
        logic exp_g[3];
        logic [31:0] exp_d[3];
        logic g;
        int   n;

        vt[0]  = '{1'b0, 4'b0110, 32'd10,        32'd10,        32'd0,          1'b1, 1'b0, 2};
        vt[1]  = '{1'b0, 4'b0000, 32'h0000F0F0,  32'h0000FF00,  32'h0000F000,   1'b0, 1'b0, 2};
        vt[2]  = '{1'b1, 4'b0001, 32'h000000F0,  32'h0000000F,  32'h000000FF,   1'b0, 1'b0, 2};
        vt[3]  = '{1'b0, 4'b0010, 32'hFFFFFFFF,  32'd1,         32'd0,          1'b1, 1'b0, 2};
        vt[4]  = '{1'b1, 4'b0111, 32'hFFFFFFFF,  32'd1,         32'd1,          1'b0, 1'b0, 2};
        vt[5]  = '{1'b0, 4'b1000, 32'hFFFFFFFF,  32'd1,         32'd0,          1'b1, 1'b0, 2};
        vt[6]  = '{1'b1, 4'b1001, 32'hAAAA5555,  32'hFFFF0000,  32'h55555555,   1'b0, 1'b0, 2};
        vt[7]  = '{1'b0, 4'b1010, 32'd1,         32'd5,         32'd32,         1'b0, 1'b0, 2};
        vt[8]  = '{1'b1, 4'b1011, 32'h80000000,  32'd4,         32'h08000000,   1'b0, 1'b0, 2};
        vt[9]  = '{1'b0, 4'b1100, 32'h80000000,  32'd4,         32'hF8000000,   1'b0, 1'b0, 2};
        vt[10] = '{1'b1, 4'b1111, 32'd5,         32'd6,         32'd0,          1'b0, 1'b1, 1};
        vt[11] = '{1'b0, 4'b0011, 32'd5,         32'd6,         32'd0,          1'b0, 1'b1, 1};

        rst_n = 1'b0;
        core_req_valid = 1'b0; core_req_ctrl = 4'd0; core_req_a = '0; core_req_b = '0; core_rsp_ready = 1'b0;
        cop_req_valid  = 1'b0; cop_req_ctrl  = 4'd0; cop_req_a  = '0; cop_req_b  = '0; cop_rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rsp_valid", {30'd0, core_rsp_valid, cop_rsp_valid}, 32'd0);
        chk("reset req_ready", {30'd0, core_req_ready, cop_req_ready}, 32'd0);
        chk("reset rsp_data", core_rsp_data, 32'd0);
        chk("reset zero_err", {28'd0, core_rsp_zero, core_rsp_err, cop_rsp_zero, cop_rsp_err}, 32'd0);
        chk("reset alu_ctrl", {28'd0, alu_ctrl_o}, 32'd2);
        chk("reset alu_ab", alu_a_o | alu_b_o, 32'd0);

        for (int i = 0; i < 12; i++) run_op($sformatf("vec%0d", i), vt[i]);

        // back-to-back conflict, both requesters hold valid throughout
        exp_d[0] = 32'd7;
`ifdef ALU_ARB_RR_EN
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;
        exp_d[1] = 32'd32; exp_d[2] = 32'd7;
`else
        exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0;
        exp_d[1] = 32'd7;  exp_d[2] = 32'd7;
`endif
        // put the round-robin pointer back on cop by issuing a lone cop op
        run_op("rr_prime", vt[2]);
        @(negedge clk);
        core_rsp_ready = 1'b1; cop_rsp_ready = 1'b1;
        drive_req(1'b0, 4'b0010, 32'd3, 32'd4);
        drive_req(1'b1, 4'b1010, 32'd1, 32'd5);
        #1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!(core_req_ready || cop_req_ready) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            g = cop_req_ready;
            chk($sformatf("conflict grant%0d", k), {31'd0, g}, {31'd0, exp_g[k]});
            @(posedge clk); #1;
            n = 0;
            @(negedge clk); #1;
            while (!(g ? cop_rsp_valid : core_rsp_valid) && n < 20) begin
                @(negedge clk); #1; n++;
            end
            chk($sformatf("conflict data%0d", k), g ? cop_rsp_data : core_rsp_data, exp_d[k]);
            @(negedge clk); #1;
        end
        core_req_valid = 1'b0; cop_req_valid = 1'b0;
        repeat (4) @(negedge clk);

        // response back-pressure with a pending cop request
        core_rsp_ready = 1'b0; cop_rsp_ready = 1'b1;
        drive_req(1'b0, 4'b1100, 32'h80000000, 32'd4);
        #1;
        chk("stall core accept", {31'd0, core_req_ready}, 32'd1);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        drive_req(1'b1, 4'b0010, 32'd3, 32'd4);
        @(negedge clk); #1;
        chk("stall exec cop_ready", {31'd0, cop_req_ready}, 32'd0);
        @(negedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall valid%0d", k), {31'd0, core_rsp_valid}, 32'd1);
            chk($sformatf("stall data%0d", k), core_rsp_data, 32'hF8000000);
            chk($sformatf("stall cop_ready%0d", k), {31'd0, cop_req_ready}, 32'd0);
            if (k < 4) begin @(negedge clk); #1; end
        end
        core_rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("release core_rsp_valid", {31'd0, core_rsp_valid}, 32'd0);
        chk("release cop_ready", {31'd0, cop_req_ready}, 32'd1);
        @(posedge clk); #1;
        cop_req_valid = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("pending cop rsp_valid", {31'd0, cop_rsp_valid}, 32'd1);
        chk("pending cop data", cop_rsp_data, 32'd7);
        @(negedge clk);

        // reset while the FSM is in EXEC
        drive_req(1'b0, 4'b0010, 32'd3, 32'd4);
        @(posedge clk); #1;
        core_req_valid = 1'b0;
        @(negedge clk); #1;
        chk("exec busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst alu_ctrl", {28'd0, alu_ctrl_o}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst no rsp%0d", k), {30'd0, core_rsp_valid, cop_rsp_valid}, 32'd0);
        end
        run_op("after_reset", vt[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, limit 200000 required");
        $fatal(1);
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Arbitrates a single shared integer ALU between the RISC-V core's execute stage and the ML coprocessor. Each requester issues an operation through a valid/ready request channel and receives its result through a valid/ready response channel. The block sequences the ALU through a three-state FSM, registers operands and result, and rejects control codes the ALU does not implement. It sits between the two requesters and the ALU, and drives the ALU's 4-bit control input directly.

## Interface
- XLEN, 32, operand/result width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- core_req_valid / cop_req_valid  in  1  request present
- core_req_ready / cop_req_ready  out  1  request accepted this cycle
- core_req_ctrl / cop_req_ctrl  in  4  ALU control code
- core_req_a, core_req_b / cop_req_a, cop_req_b  in  XLEN  operands
- core_rsp_valid / cop_rsp_valid  out  1  response present
- core_rsp_ready / cop_rsp_ready  in  1  response consumed
- core_rsp_data / cop_rsp_data  out  XLEN  ALU result
- core_rsp_zero / cop_rsp_zero  out  1  ALU zero flag
- core_rsp_err / cop_rsp_err  out  1  illegal control code
- alu_ctrl_o  out  4  to ALU control input
- alu_a_o, alu_b_o  out  XLEN  to ALU operands
- alu_result_i  in  XLEN  from ALU
- alu_zero_i  in  1  from ALU
- busy  out  1  FSM not in IDLE

## Operation
- **Legal codes:** 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 XOR, 1010 SLL, 1011 SRL, 1100 SRA. Every other code is illegal.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - Compute the grant from the valid requests.
  - Assert ready only to the granted requester. Ready may depend on valid; valid must never depend on ready.
  - On valid&ready, latch ctrl, a and b, and record the owner.
  - Legal code: go to EXEC. Illegal code: go directly to RESP with err=1, data=0, zero=0.
- **EXEC (one cycle):**
  - Drive alu_ctrl_o, alu_a_o and alu_b_o from the latched registers.
  - Capture alu_result_i and alu_zero_i into the response register, with err=0.
  - Go to RESP.
- **RESP:**
  - Assert rsp_valid to the owner only. Data, zero and err stay stable.
  - On owner rsp_ready, go to IDLE. Otherwise hold.
- **Outside EXEC:** alu_ctrl_o=0010, alu_a_o=0, alu_b_o=0.
- **Flow control:** both req_ready signals are 0 outside IDLE. Requests stay pending, and a requester must hold valid and its payload until accepted.
- **Grant with a single valid:** that requester is granted.
- **Grant with both valid:** selected per Configuration.
- **Reset:** rst_n low in any state puts the FSM in IDLE at the next edge. The in-flight operation is dropped and no response is issued. Reset values:
  - all ready and rsp_valid outputs: 0
  - rsp_data: 0; rsp_zero and rsp_err: 0
  - alu_ctrl_o: 0010; alu_a_o and alu_b_o: 0
  - busy: 0
  - last-grant register: cop

## Timing
- **Accept:** edge N (valid&ready in cycle N-1). EXEC occupies cycle N. rsp_valid is high in cycle N+1 at the earliest (two-cycle latency).
- **Illegal code:** rsp_valid is high in cycle N, one cycle after accept.
- **Response handshake:** if rsp_ready is already high when rsp_valid rises, the transfer completes that cycle. IDLE follows, and the next accept can occur the cycle after. Peak throughput is one op per 3 cycles.
- **Grant updates:** the last-grant register updates only on accept.
- **Owner's valid while busy:** a new request from the owner during RESP is not accepted until IDLE.
- **Response routing:** the non-owner's rsp_valid stays 0 throughout, and the non-owner's rsp_ready is ignored.

## Configuration
- **ALU_ARB_RR_EN defined:** round-robin. On conflict, grant the requester that was not granted last. Since the last-grant register resets to cop, the core wins the first conflict.
- **ALU_ARB_RR_EN undefined:** fixed priority. The core always wins a conflict, and the last-grant register is unused.

## Test plan
- Core only, ctrl=0110, a=10, b=10, rsp_ready=1: core_rsp_valid two cycles after accept, data=0, zero=1, err=0. cop_rsp_valid stays 0.
- Both valid continuously, core ADD 3+4, cop SLL 1<<5, ALU_ARB_RR_EN defined:
  - grants alternate core, cop, core.
  - responses 7, 32, 7.
  - Without the macro, only core is granted while its valid stays high.
- Cop ctrl=1111: rejected with cop_rsp_err=1, data=0, one cycle after accept. alu_ctrl_o stays 0010 throughout.
- Core SRA a=0x80000000 b=4, core_rsp_ready held 0 for 5 cycles:
  - rsp_valid and data=0xF8000000 stay stable.
  - cop_req_ready stays 0 until release; the pending cop request is accepted the cycle after IDLE.
- rst_n low during EXEC: next edge is IDLE, busy=0, no rsp_valid. A request made after reset completes normally.
